bus_bit_serializer: RTL

- Downstream consumer of the 5-bit descending bus `o0[2:-2]` driven by the `model` cell.
- Captures one parallel word through a valid/ready handshake and shifts it out one bit per accepted beat on a serial valid/ready channel.
- Each serial beat carries first/last framing and the signed bit index being sent.
- Used by netlist regression designs that need real sequential logic on negative-index buses.

---
 rtl/bus_bit_serializer.sv | 139 +++++++++++++
 1 files changed

// File: rtl/bus_bit_serializer.sv
// bus_bit_serializer
//
// Accepts one parallel word from a descending [HI:LO] bus through a
// valid/ready handshake. It then sends that word one bit per accepted beat
// on a serial valid/ready channel. Each beat carries first/last framing and
// the signed bus index of the bit being sent. The next parallel word can be
// accepted in the same cycle as the last beat, so a continuous stream leaves
// no bubble between words.
//
// Ports
//   clk         rising-edge clock
//   rst_n       asynchronous active-low reset
//   par_data    parallel word [HI:LO]
//   par_valid   parallel word offered
//   par_ready   word can be accepted this cycle
//   ser_bit     current serial bit
//   ser_idx     signed bus index of ser_bit (IDX_W bits, sign-extended)
//   ser_first   beat is the first bit of a word
//   ser_last    beat is the last bit of a word
//   ser_valid   serial beat valid
//   ser_ready   downstream accepts the beat
//   words_sent  count of fully transmitted words, wraps at 256
module bus_bit_serializer #(
    parameter int HI        = 2,
    parameter int LO        = -2,
    parameter bit MSB_FIRST = 1'b0,
    parameter int IDX_W     = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [HI:LO]            par_data,
    input  logic                    par_valid,
    output logic                    par_ready,
    output logic                    ser_bit,
    output logic signed [IDX_W-1:0] ser_idx,
    output logic                    ser_first,
    output logic                    ser_last,
    output logic                    ser_valid,
    input  logic                    ser_ready,
    output logic [7:0]              words_sent
);

    localparam int W     = HI - LO + 1;
    localparam int CNT_W = (W > 1) ? $clog2(W) : 1;

    localparam logic [CNT_W-1:0]        CNT_MAX   = CNT_W'(W - 1);
    localparam logic signed [IDX_W-1:0] IDX_FIRST = MSB_FIRST ? IDX_W'(HI) : IDX_W'(LO);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t                  state_q, state_d;
    logic [HI:LO]            shreg_q, shreg_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic signed [IDX_W-1:0] idx_q, idx_d;
    logic [7:0]              words_q, words_d;

    logic shifting;
    logic cnt_zero;

    assign shifting = (state_q == SHIFT);
    assign cnt_zero = (cnt_q == '0);

    // Serial outputs come only from registers. They are forced to zero
    // outside SHIFT, so IDLE and reset present a quiet channel.
    assign ser_valid  = shifting;
    assign ser_bit    = shifting & (MSB_FIRST ? shreg_q[HI] : shreg_q[LO]);
    assign ser_idx    = shifting ? idx_q : '0;
    assign ser_first  = shifting & (cnt_q == CNT_MAX);
    assign ser_last   = shifting & cnt_zero;
    assign words_sent = words_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            shreg_q <= '0;
            cnt_q   <= '0;
            idx_q   <= '0;
            words_q <= '0;
        end else begin
            state_q <= state_d;
            shreg_q <= shreg_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            words_q <= words_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        shreg_d   = shreg_q;
        cnt_d     = cnt_q;
        idx_d     = idx_q;
        words_d   = words_q;
        par_ready = 1'b0;

        case (state_q)
            IDLE: begin
                par_ready = 1'b1;
                if (par_valid) begin
                    shreg_d = par_data;
                    cnt_d   = CNT_MAX;
                    idx_d   = IDX_FIRST;
                    state_d = SHIFT;
                end
            end

            SHIFT: begin
                if (ser_ready) begin
                    if (cnt_zero) begin
                        // The last beat leaves this cycle, so a new word can
                        // be loaded straight behind it.
                        words_d   = words_q + 8'd1;
                        par_ready = 1'b1;
                        if (par_valid) begin
                            shreg_d = par_data;
                            cnt_d   = CNT_MAX;
                            idx_d   = IDX_FIRST;
                        end else begin
                            state_d = IDLE;
                        end
                    end else begin
                        // Move the next bit onto the send edge.
                        shreg_d = MSB_FIRST ? (shreg_q << 1) : (shreg_q >> 1);
                        cnt_d   = cnt_q - CNT_W'(1);
                        idx_d   = MSB_FIRST ? (idx_q - IDX_W'(1)) : (idx_q + IDX_W'(1));
                    end
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

endmodule
